// File: rtl/riscv_defs_pkg.sv
// ---------------------------------------------------------------------------
// riscv_defs : RV32I encoding constants shared by fetch_decode_regs and
// Control_Unit.
//   - Major opcode constants (LW, SW, RTYPE, ITYPE, JAL, BRANCH, JALR,
//     AUIPC, LUI)
//   - Branch funct3 codes
//   - NOP_INSTR (addi x0,x0,0), the IR value after reset
//   - rv_instr_t: packed view of the base instruction fields
//   - imm_fmt_e / imm_fmt(): opcode -> immediate format classification
// ---------------------------------------------------------------------------
package riscv_defs;

  localparam logic [6:0] OPC_LW     = 7'b000_0011;
  localparam logic [6:0] OPC_SW     = 7'b010_0011;
  localparam logic [6:0] OPC_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OPC_ITYPE  = 7'b001_0011;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Field order matches the bit positions of the base encoding, so a
  // 32-bit word can be cast straight onto it.
  typedef struct packed {
    logic [6:0] funct7;   // [31:25]
    logic [4:0] rs2;      // [24:20]
    logic [4:0] rs1;      // [19:15]
    logic [2:0] funct3;   // [14:12]
    logic [4:0] rd;       // [11:7]
    logic [6:0] opcode;   // [6:0]
  } rv_instr_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    imm_fmt_e f;
    case (opc)
      OPC_LW, OPC_ITYPE, OPC_JALR: f = IMM_I;
      OPC_SW:                      f = IMM_S;
      OPC_BRANCH:                  f = IMM_B;
      OPC_LUI, OPC_AUIPC:          f = IMM_U;
      OPC_JAL:                     f = IMM_J;
      default:                     f = IMM_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fetch_decode_regs_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen : purely combinational immediate decoder.
//   instr_i  in  32  instruction word (IR)
//   imm_o    out 32  sign-extended immediate; 0 for opcodes without one
// Bit 31 of the instruction is always the sign source. B and J immediates
// have bit 0 forced to 0, U immediates have the low 12 bits zero.
// ---------------------------------------------------------------------------
module imm_gen
  import riscv_defs::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o
);

  imm_fmt_e fmt;

  assign fmt = imm_fmt(instr_i[6:0]);

  always_comb begin
    imm_o = '0;
    case (fmt)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'h000};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_regs.sv
// ---------------------------------------------------------------------------
// fetch_decode_regs : architectural PC / IR stage of the multi-cycle RV32I
// core. Driven by Control_Unit strobes; holds PC, OldPC, IR, MDR and the
// retired-instruction counter, and presents decoded IR fields.
//
// Ports
//   clk, rst_n            clock / async active-low reset
//   pc_write_i            unconditional PC load
//   pc_write_cond_i       PC load if the branch in IR is taken
//   pc_source_i           0: next PC = alu_result_i, 1: next PC = alu_out_i
//   ir_write_i            IR <= mem_rdata_i, old_pc <= pc, instret++
//   alu_result_i          combinational ALU result
//   alu_out_i             registered ALUOut
//   alu_zero_i            ALU zero flag (branch compare result)
//   mem_rdata_i           memory read data
//   pc_o / old_pc_o       current PC / PC of the instruction held in IR
//   instruction_o         IR contents
//   opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o   IR fields
//   immediate_o           sign-extended immediate of IR
//   mdr_o                 memory data register (mem_rdata one cycle late)
//   instret_o             64-bit count of ir_write strobes (wraps)
//   pc_misaligned_o       registered pulse: last PC load had next_pc[1]=1
// ---------------------------------------------------------------------------
module fetch_decode_regs #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR    = riscv_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write_i,
  input  logic        pc_write_cond_i,
  input  logic        pc_source_i,
  input  logic        ir_write_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_out_i,
  input  logic        alu_zero_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] old_pc_o,
  output logic [31:0] instruction_o,
  output logic [6:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic [31:0] immediate_o,
  output logic [31:0] mdr_o,
  output logic [63:0] instret_o,
  output logic        pc_misaligned_o
);
  import riscv_defs::*;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  rv_instr_t   ir_q, ir_d;
  logic [31:0] mdr_q;
  logic [63:0] instret_q, instret_d;
  logic        pc_mis_q, pc_mis_d;

  logic [31:0] next_pc;
  logic        taken;
  logic        pc_en;

  // -------------------------------------------------------------------------
  // Branch resolution. The ALU runs a subtract/compare in branch mode, so
  // the zero flag means "equal" for BEQ and "condition false" for the
  // set-less-than based compares; each pair is the other's inverse.
  // -------------------------------------------------------------------------
  always_comb begin
    taken = 1'b0;
    case (ir_q.funct3)
      F3_BEQ, F3_BGE, F3_BGEU: taken = alu_zero_i;
      F3_BNE, F3_BLT, F3_BLTU: taken = ~alu_zero_i;
      default:                 taken = 1'b0;
    endcase
  end

  assign next_pc = pc_source_i ? alu_out_i : alu_result_i;
  assign pc_en   = pc_write_i | (pc_write_cond_i & taken);

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    old_pc_d  = old_pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    // Bit 0 is dropped silently (JALR target rule); bit 1 is dropped too
    // but reported through the misaligned pulse.
    pc_mis_d  = pc_en & next_pc[1];
    if (pc_en) begin
      pc_d = {next_pc[31:2], 2'b00};
    end
    if (ir_write_i) begin
      ir_d      = rv_instr_t'(mem_rdata_i);
      old_pc_d  = pc_q;                 // pre-update PC, also during FETCH
      instret_d = instret_q + 64'd1;    // wraps at 2^64
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VECTOR;
      old_pc_q  <= RESET_VECTOR;
      ir_q      <= rv_instr_t'(NOP_INSTR);
      mdr_q     <= '0;
      instret_q <= '0;
      pc_mis_q  <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      old_pc_q  <= old_pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mem_rdata_i;
      instret_q <= instret_d;
      pc_mis_q  <= pc_mis_d;
    end
  end

  // -------------------------------------------------------------------------
  // Decode (combinational from IR)
  // -------------------------------------------------------------------------
  imm_gen u_imm_gen (
    .instr_i (ir_q),
    .imm_o   (immediate_o)
  );

  assign pc_o            = pc_q;
  assign old_pc_o        = old_pc_q;
  assign instruction_o   = ir_q;
  assign opcode_o        = ir_q.opcode;
  assign rd_o            = ir_q.rd;
  assign rs1_o           = ir_q.rs1;
  assign rs2_o           = ir_q.rs2;
  assign funct3_o        = ir_q.funct3;
  assign funct7_o        = ir_q.funct7;
  assign mdr_o           = mdr_q;
  assign instret_o       = instret_q;
  assign pc_misaligned_o = pc_mis_q;

endmodule
